// File: rtl/hi_xcorr_pkg.sv
// Shared encodings for the HF cross-correlation receive-window sequencer.
package hi_xcorr_pkg;

    localparam logic [1:0] MODE_848  = 2'b00;
    localparam logic [1:0] MODE_424  = 2'b01;
    localparam logic [1:0] MODE_212  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int unsigned FRAME_SAMPLES = 64;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StGuard,
        StRx,
        StDone
    } sched_state_e;

    // Returns {xcorr_is_848, xcorr_quarter_freq} for a subcarrier mode.
    function automatic logic [1:0] mode_pins(input logic [1:0] mode);
        logic [1:0] pins;
        case (mode)
            MODE_848: pins = 2'b10;
            MODE_424: pins = 2'b00;
            MODE_212: pins = 2'b11;
            default:  pins = 2'b10;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/hi_xcorr_frame_cnt.sv
// Loadable frame down-counter; last flags that the next tick ends the count.
module hi_xcorr_frame_cnt #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/hi_xcorr_sched.sv
// Receive-window sequencer: latches a config, switches mode pins on a frame
// boundary, waits out the guard frames, then gates SSP reports for the window.
module hi_xcorr_sched
    import hi_xcorr_pkg::*;
#(
    parameter int unsigned GUARD_W = 12,
    parameter int unsigned WIN_W   = 16
) (
    input  logic               ck_1356meg,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_snoop,
    input  logic [GUARD_W-1:0] cfg_guard,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               abort,
    input  logic               frame_tick,
    output logic               xcorr_is_848,
    output logic               xcorr_quarter_freq,
    output logic               snoop,
    output logic               rx_gate,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               cfg_err,
    output logic [WIN_W-1:0]   rx_frames
);

    sched_state_e       state;
    logic [1:0]         mode_sh;
    logic               snoop_sh;
    logic [GUARD_W-1:0] guard_sh;
    logic [WIN_W-1:0]   window_sh;

    logic tick_ok, abort_hit, enter_rx;
    logic guard_load, guard_tick, guard_last;
    logic win_tick, win_last;

    // abort beats a coincident frame_tick, so no counting on that edge
    assign tick_ok    = frame_tick && !abort;
    assign abort_hit  = abort && (state == StArm || state == StGuard || state == StRx);
    assign guard_load = tick_ok && (state == StArm);
    assign guard_tick = tick_ok && (state == StGuard);
    assign win_tick   = tick_ok && (state == StRx);
    assign enter_rx   = tick_ok && ((state == StArm && guard_sh == '0) ||
                                    (state == StGuard && guard_last));

    hi_xcorr_frame_cnt #(.W(GUARD_W)) u_guard_cnt (
        .clk      (ck_1356meg),
        .rst_n    (reset_n),
        .load     (guard_load),
        .load_val (guard_sh),
        .tick     (guard_tick),
        .last     (guard_last)
    );

    hi_xcorr_frame_cnt #(.W(WIN_W)) u_win_cnt (
        .clk      (ck_1356meg),
        .rst_n    (reset_n),
        .load     (enter_rx),
        .load_val (window_sh),
        .tick     (win_tick),
        .last     (win_last)
    );

    always_ff @(posedge ck_1356meg or negedge reset_n) begin
        if (!reset_n) begin
            state              <= StIdle;
            mode_sh            <= MODE_848;
            snoop_sh           <= 1'b0;
            guard_sh           <= '0;
            window_sh          <= '0;
            cfg_ready          <= 1'b1;
            xcorr_is_848       <= 1'b1;
            xcorr_quarter_freq <= 1'b0;
            snoop              <= 1'b0;
            rx_gate            <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            cfg_err            <= 1'b0;
            rx_frames          <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            cfg_err <= 1'b0;
            if (abort_hit) begin
                state     <= StIdle;
                rx_gate   <= 1'b0;
                snoop     <= 1'b0;
                aborted   <= 1'b1;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (cfg_valid) begin
                            if (cfg_mode == MODE_RSVD) begin
                                cfg_err <= 1'b1;
                            end else begin
                                mode_sh   <= cfg_mode;
                                snoop_sh  <= cfg_snoop;
                                guard_sh  <= cfg_guard;
                                window_sh <= cfg_window;
                                rx_frames <= '0;
                                state     <= StArm;
                                busy      <= 1'b1;
                                cfg_ready <= 1'b0;
                            end
                        end
                    end
                    StArm: begin
                        if (frame_tick) begin
                            {xcorr_is_848, xcorr_quarter_freq} <= mode_pins(mode_sh);
                            snoop <= snoop_sh;
                            state <= StGuard;
                        end
                    end
                    StGuard: begin
                    end
                    StRx: begin
                        if (frame_tick) begin
                            if (rx_frames != '1) begin
                                rx_frames <= rx_frames + WIN_W'(1);
                            end
                            if (win_last) begin
                                state   <= StDone;
                                rx_gate <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        state     <= StIdle;
                        snoop     <= 1'b0;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase

                // An empty window skips RX entirely and finishes with no gated frames
                if (enter_rx) begin
                    if (window_sh == '0) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        state   <= StRx;
                        rx_gate <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hi_xcorr_sched.sv
// Bench for hi_xcorr_sched: tick-count window model checked every cycle, plus
// literal expectations at the key points of each directed scenario.
module tb_hi_xcorr_sched;

    localparam int unsigned GUARD_W = 12;
    localparam int unsigned WIN_W   = 16;

    logic               ck_1356meg = 1'b0;
    logic               reset_n    = 1'b0;
    logic               cfg_valid  = 1'b0;
    logic [1:0]         cfg_mode   = 2'b00;
    logic               cfg_snoop  = 1'b0;
    logic [GUARD_W-1:0] cfg_guard  = '0;
    logic [WIN_W-1:0]   cfg_window = '0;
    logic               abort      = 1'b0;
    logic               frame_tick = 1'b0;

    logic             cfg_ready, xcorr_is_848, xcorr_quarter_freq, snoop, rx_gate;
    logic             busy, done, aborted, cfg_err;
    logic [WIN_W-1:0] rx_frames;

    hi_xcorr_sched #(.GUARD_W(GUARD_W), .WIN_W(WIN_W)) dut (
        .ck_1356meg         (ck_1356meg),
        .reset_n            (reset_n),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_mode           (cfg_mode),
        .cfg_snoop          (cfg_snoop),
        .cfg_guard          (cfg_guard),
        .cfg_window         (cfg_window),
        .abort              (abort),
        .frame_tick         (frame_tick),
        .xcorr_is_848       (xcorr_is_848),
        .xcorr_quarter_freq (xcorr_quarter_freq),
        .snoop              (snoop),
        .rx_gate            (rx_gate),
        .busy               (busy),
        .done               (done),
        .aborted            (aborted),
        .cfg_err            (cfg_err),
        .rx_frames          (rx_frames)
    );

    initial forever #5 ck_1356meg = ~ck_1356meg;

    int total = 0;
    int bad   = 0;
    int gate_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 window in progress, 2 done cycle. Tick n (1-based,
    // counted from acceptance) applies the mode at n=1, gates ticks g+1..g+w,
    // and the window ends at tick g+1+w.
    logic [1:0] pin_tab [4] = '{2'b10, 2'b00, 2'b11, 2'b10};
    int         ph, mn, mg, mw, k;
    logic [1:0] mm;
    logic       ms;
    logic       e_ready, e_848, e_qf, e_snoop, e_gate, e_busy, e_done, e_abt, e_err;
    logic [WIN_W-1:0] e_frames;

    task model_reset();
        ph = 0; mn = 0; mg = 0; mw = 0; mm = 2'b00; ms = 1'b0;
        e_ready = 1'b1; e_848 = 1'b1; e_qf = 1'b0; e_snoop = 1'b0; e_gate = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_abt = 1'b0; e_err = 1'b0; e_frames = '0;
    endtask

    task model_step();
        e_done = 1'b0; e_abt = 1'b0; e_err = 1'b0;
        case (ph)
            0: begin
                if (cfg_valid) begin
                    if (cfg_mode == 2'b11) begin
                        e_err = 1'b1;
                    end else begin
                        mm = cfg_mode; ms = cfg_snoop;
                        mg = int'(cfg_guard); mw = int'(cfg_window);
                        mn = 0; e_frames = '0; ph = 1;
                    end
                end
            end
            1: begin
                if (abort) begin
                    ph = 0; e_abt = 1'b1; e_gate = 1'b0; e_snoop = 1'b0;
                end else if (frame_tick) begin
                    mn++;
                    if (mn == 1) begin
                        e_848 = pin_tab[mm][1]; e_qf = pin_tab[mm][0]; e_snoop = ms;
                    end
                    e_gate = (mn >= mg + 1) && (mn < mg + 1 + mw);
                    k = mn - mg - 1;
                    if (k < 0) k = 0;
                    if (k > mw) k = mw;
                    e_frames = WIN_W'(k);
                    if (mn == mg + 1 + mw) begin
                        ph = 2; e_done = 1'b1;
                    end
                end
            end
            default: begin
                ph = 0; e_snoop = 1'b0;
            end
        endcase
        e_busy = (ph != 0);
        e_ready = (ph == 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge ck_1356meg or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(posedge ck_1356meg);
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(e_ready));
        check("is_848", 32'(xcorr_is_848), 32'(e_848));
        check("quarter", 32'(xcorr_quarter_freq), 32'(e_qf));
        check("snoop", 32'(snoop), 32'(e_snoop));
        check("rx_gate", 32'(rx_gate), 32'(e_gate));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("aborted", 32'(aborted), 32'(e_abt));
        check("cfg_err", 32'(cfg_err), 32'(e_err));
        check("rx_frames", 32'(rx_frames), 32'(e_frames));
        if (rx_gate) gate_cycles++;
    end

    task automatic send_cfg(input logic [1:0] m, input logic s, input int g, input int w);
        @(negedge ck_1356meg);
        cfg_valid = 1'b1; cfg_mode = m; cfg_snoop = s;
        cfg_guard = GUARD_W'(g); cfg_window = WIN_W'(w);
        @(negedge ck_1356meg);
        cfg_valid = 1'b0;
    endtask

    // Each frame is 64 cycles with the tick in the last one.
    task automatic frames(input int n, input logic abort_last);
        for (int i = 0; i < n; i++) begin
            repeat (63) @(negedge ck_1356meg);
            frame_tick = 1'b1;
            if (abort_last && i == n - 1) abort = 1'b1;
            @(negedge ck_1356meg);
            frame_tick = 1'b0;
            abort = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge ck_1356meg);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_pins", {30'd0, xcorr_is_848, xcorr_quarter_freq}, 32'd2);
        reset_n = 1'b1;

        // Reset in the middle of RX
        send_cfg(2'b01, 1'b1, 3, 10);
        check("hs_busy", 32'(busy), 32'd1);
        frames(4, 1'b0);
        check("mid_rx_gate", 32'(rx_gate), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_gate", 32'(rx_gate), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(cfg_ready), 32'd1);
        check("async_rst_pins", {30'd0, xcorr_is_848, xcorr_quarter_freq}, 32'd2);
        check("async_rst_snoop", 32'(snoop), 32'd0);
        @(negedge ck_1356meg);
        reset_n = 1'b1;

        // 424 kHz, guard 2, window 3
        gate_cycles = 0;
        send_cfg(2'b01, 1'b0, 2, 3);
        frames(1, 1'b0);
        check("m424_pins", {30'd0, xcorr_is_848, xcorr_quarter_freq}, 32'd0);
        frames(2, 1'b0);
        check("m424_gate_up", 32'(rx_gate), 32'd1);
        frames(3, 1'b0);
        check("m424_gate_down", 32'(rx_gate), 32'd0);
        check("m424_done", 32'(done), 32'd1);
        check("m424_frames", 32'(rx_frames), 32'd3);
        @(negedge ck_1356meg);
        check("m424_ready_back", 32'(cfg_ready), 32'd1);
        check("m424_gate_cycles", 32'(gate_cycles), 32'd192);

        // 212 kHz snoop, guard 0, window 1
        gate_cycles = 0;
        send_cfg(2'b10, 1'b1, 0, 1);
        frames(1, 1'b0);
        check("m212_pins", {30'd0, xcorr_is_848, xcorr_quarter_freq}, 32'd3);
        check("m212_snoop", 32'(snoop), 32'd1);
        frames(1, 1'b0);
        check("m212_done", 32'(done), 32'd1);
        @(negedge ck_1356meg);
        check("m212_snoop_off", 32'(snoop), 32'd0);
        check("m212_gate_cycles", 32'(gate_cycles), 32'd64);

        // Reserved mode rejected
        send_cfg(2'b11, 1'b0, 1, 1);
        check("rsvd_err", 32'(cfg_err), 32'd1);
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_pins", {30'd0, xcorr_is_848, xcorr_quarter_freq}, 32'd3);
        @(negedge ck_1356meg);
        abort = 1'b1;
        @(negedge ck_1356meg);
        abort = 1'b0;
        check("idle_abort_ignored", 32'(aborted), 32'd0);

        // Abort coincident with the 5th RX tick
        send_cfg(2'b00, 1'b0, 1, 100);
        frames(6, 1'b0);
        frames(1, 1'b1);
        check("abt_pulse", 32'(aborted), 32'd1);
        check("abt_no_done", 32'(done), 32'd0);
        check("abt_frames", 32'(rx_frames), 32'd4);
        check("abt_gate", 32'(rx_gate), 32'd0);

        // Empty window, cfg_valid held through busy
        gate_cycles = 0;
        @(negedge ck_1356meg);
        cfg_valid = 1'b1; cfg_mode = 2'b00; cfg_snoop = 1'b0;
        cfg_guard = '0; cfg_window = '0;
        @(negedge ck_1356meg);
        check("empty_busy", 32'(busy), 32'd1);
        frames(1, 1'b0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_frames", 32'(rx_frames), 32'd0);
        check("empty_gate_cycles", 32'(gate_cycles), 32'd0);
        @(negedge ck_1356meg);
        check("held_ready_idle", 32'(cfg_ready), 32'd1);
        @(negedge ck_1356meg);
        check("held_reaccept", 32'(busy), 32'd1);
        cfg_valid = 1'b0;
        abort = 1'b1;
        @(negedge ck_1356meg);
        abort = 1'b0;
        check("arm_abort", 32'(aborted), 32'd1);

        repeat (5) @(negedge ck_1356meg);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
